adc_stim_gen: RTL and testbench

Parametrised multi-channel ADC stimulus source for the top-level benches. It generalises the fixed per-channel ramp counters and the periodic trigger counter into one block. Each channel has a run-time mode (hold, sawtooth, triangle, LFSR noise), bounds, step and sample-rate divider. The block also emits a periodic trigger with programmable period and polarity. Outputs feed adc_driver data inputs and the external trigger GPIO.

---
 rtl/adc_stim_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_adc_stim_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stim_gen.sv
// Multi-channel ADC stimulus source: per-channel hold / sawtooth / triangle /
// LFSR waveforms advanced by a shared sample-rate divider, plus a periodic
// trigger pulse with a running trigger count.

// Per-channel waveform engine. Holds the sample, the triangle direction and
// the LFSR state; advances only when the shared divider fires.
module adc_stim_ch #(
  parameter int DW   = 14,
  parameter int CFGW = 2 + 4*DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld,
  input  logic            adv,
  input  logic [CFGW-1:0] cfg_v,
  output logic [DW-1:0]   dat
);

  typedef enum logic [1:0] {MD_HOLD, MD_SAW, MD_TRI, MD_LFSR} mode_t;

  typedef struct packed {
    logic [1:0]    mode;
    logic [DW-1:0] init;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [DW-1:0] step;
  } cfg_t;

  // Galois toggle masks of maximal-length polynomials, indexed by width.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      12:      lfsr_taps = 16'h0E08;
      13:      lfsr_taps = 16'h1C80;
      14:      lfsr_taps = 16'h3802;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]   TAP16 = lfsr_taps(DW);
  localparam logic [DW-1:0] TAPS  = TAP16[DW-1:0];

  cfg_t          cfg;
  logic          dir_dn;
  logic [DW-1:0] lfsr;

  logic          dir_nx;
  logic [DW-1:0] dat_nx, lfsr_nx;

  // Two guard bits: a full-scale unsigned step added to a full-scale signed
  // sample can never wrap before it is clamped.
  logic signed [DW+1:0] dat_e, lo_e, hi_e, stp_e, sum, dif;
  logic [DW-1:0]        up_sat, dn_sat;
  logic                 at_hi, at_lo;

  assign cfg = cfg_v;

  // Sign-extended operands and the clamped up/down candidates.
  always_comb begin
    dat_e  = {{2{dat[DW-1]}},      dat};
    lo_e   = {{2{cfg.lo[DW-1]}},   cfg.lo};
    hi_e   = {{2{cfg.hi[DW-1]}},   cfg.hi};
    stp_e  = {2'b00, cfg.step};
    sum    = dat_e + stp_e;
    dif    = dat_e - stp_e;
    up_sat = (sum > hi_e) ? cfg.hi : sum[DW-1:0];
    dn_sat = (dif < lo_e) ? cfg.lo : dif[DW-1:0];
    at_hi  = (dat_e >= hi_e);
    at_lo  = (dat_e <= lo_e);
  end

  // Next sample / direction / LFSR state for one advance in the current mode.
  always_comb begin
    dat_nx  = dat;
    dir_nx  = dir_dn;
    lfsr_nx = lfsr;
    case (mode_t'(cfg.mode))
      MD_SAW: begin
        if (cfg.step != '0) dat_nx = at_hi ? cfg.lo : up_sat;
      end
      MD_TRI: begin
        if (cfg.step != '0) begin
          if (!dir_dn) begin
            if (at_hi) begin
              dir_nx = 1'b1;
              dat_nx = dn_sat;
            end else begin
              dat_nx = up_sat;
            end
          end else begin
            if (at_lo) begin
              dir_nx = 1'b0;
              dat_nx = up_sat;
            end else begin
              dat_nx = dn_sat;
            end
          end
        end
      end
      MD_LFSR: begin
        // The sample shows the current state, so the seed is the first value.
        dat_nx  = lfsr;
        lfsr_nx = {1'b0, lfsr[DW-1:1]} ^ (lfsr[0] ? TAPS : '0);
      end
      default: ;
    endcase
  end

  // Channel state: load has priority, otherwise step on the shared advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat    <= '0;
      dir_dn <= 1'b0;
      lfsr   <= DW'(1);
    end else if (ld) begin
      dat    <= cfg.init;
      dir_dn <= 1'b0;
      lfsr   <= (cfg.init == '0) ? DW'(1) : cfg.init;
    end else if (adv) begin
      dat    <= dat_nx;
      dir_dn <= dir_nx;
      lfsr   <= lfsr_nx;
    end
  end

endmodule

module adc_stim_gen #(
  parameter int NUM_CH       = 4,
  parameter int DW           = 14,
  parameter int DIVW         = 16,
  parameter int TPW          = 32,
  parameter bit TRIG_ACT_LVL = 1'b0
) (
  input  logic                 adc_clk_i,
  input  logic                 adc_rstn_i,
  input  logic                 ld_i,
  input  logic                 en_i,
  input  logic [NUM_CH*2-1:0]  mode_i,
  input  logic [NUM_CH*DW-1:0] init_i,
  input  logic [NUM_CH*DW-1:0] lo_i,
  input  logic [NUM_CH*DW-1:0] hi_i,
  input  logic [NUM_CH*DW-1:0] step_i,
  input  logic [DIVW-1:0]      div_i,
  input  logic [TPW-1:0]       trig_per_i,
  output logic [NUM_CH*DW-1:0] dat_o,
  output logic                 stb_o,
  output logic                 trig_o,
  output logic [31:0]          trig_cnt_o
);

  typedef struct packed {
    logic [1:0]    mode;
    logic [DW-1:0] init;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [DW-1:0] step;
  } cfg_t;

  localparam logic T_ON  = TRIG_ACT_LVL;
  localparam logic T_OFF = ~TRIG_ACT_LVL;

  logic [NUM_CH-1:0][1:0]    mode;
  logic [NUM_CH-1:0][DW-1:0] init, lo, hi, step, dat;

  logic [DIVW-1:0] dcnt;
  logic [TPW-1:0]  pcnt;
  logic            adv, tfire;

  assign mode  = mode_i;
  assign init  = init_i;
  assign lo    = lo_i;
  assign hi    = hi_i;
  assign step  = step_i;
  assign dat_o = dat;

  // Compares are >= so a divider/period shrunk below the live count wraps
  // at the next cycle instead of running all the way round.
  assign adv   = en_i & ~ld_i & (dcnt >= div_i);
  assign tfire = en_i & ~ld_i & (trig_per_i != '0) & (pcnt >= trig_per_i);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cfg_t cfg;
    assign cfg.mode = mode[c];
    assign cfg.init = init[c];
    assign cfg.lo   = lo[c];
    assign cfg.hi   = hi[c];
    assign cfg.step = step[c];

    adc_stim_ch #(.DW(DW)) u_ch (
      .clk   (adc_clk_i),
      .rst_n (adc_rstn_i),
      .ld    (ld_i),
      .adv   (adv),
      .cfg_v (cfg),
      .dat   (dat[c])
    );
  end

  // Shared divider, trigger period counter and their registered pulses.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      dcnt       <= '0;
      pcnt       <= '0;
      stb_o      <= 1'b0;
      trig_o     <= T_OFF;
      trig_cnt_o <= '0;
    end else if (ld_i) begin
      dcnt       <= '0;
      pcnt       <= '0;
      stb_o      <= 1'b0;
      trig_o     <= T_OFF;
      trig_cnt_o <= '0;
    end else begin
      stb_o  <= adv;
      trig_o <= tfire ? T_ON : T_OFF;
      if (en_i) begin
        dcnt <= adv ? '0 : dcnt + DIVW'(1);
        if (trig_per_i == '0 || tfire) pcnt <= '0;
        else                           pcnt <= pcnt + TPW'(1);
        if (tfire) trig_cnt_o <= trig_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_stim_gen.sv
// Directed bench for adc_stim_gen: reset, sawtooth, freeze, triangle with
// divider, LFSR sequence/period, trigger period/disable, ld priority and
// asynchronous reset.
module tb_adc_stim_gen;

  localparam int NUM_CH = 4;
  localparam int DW     = 14;
  localparam int DIVW   = 16;
  localparam int TPW    = 32;

  logic                      clk, rstn, ld, en;
  logic [NUM_CH-1:0][1:0]    mode;
  logic [NUM_CH-1:0][DW-1:0] init, lo, hi, step;
  logic [DIVW-1:0]           div;
  logic [TPW-1:0]            per;
  logic [NUM_CH*DW-1:0]      dat;
  logic                      stb, trig;
  logic [31:0]               trig_cnt;

  int checks = 0;
  int errors = 0;

  adc_stim_gen #(.NUM_CH(NUM_CH), .DW(DW), .DIVW(DIVW), .TPW(TPW), .TRIG_ACT_LVL(1'b0)) dut (
    .adc_clk_i  (clk),
    .adc_rstn_i (rstn),
    .ld_i       (ld),
    .en_i       (en),
    .mode_i     (mode),
    .init_i     (init),
    .lo_i       (lo),
    .hi_i       (hi),
    .step_i     (step),
    .div_i      (div),
    .trig_per_i (per),
    .dat_o      (dat),
    .stb_o      (stb),
    .trig_o     (trig),
    .trig_cnt_o (trig_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [31:0] d(input int ch);
    logic signed [DW-1:0] t;
    logic signed [31:0]   r;
    t = dat[ch*DW +: DW];
    r = t;
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad, n, zero, pulses, first, last, lows;
    int tri_seq [10];
    tri_seq = '{3, 6, 8, 5, 2, -1, -4, -7, -8, -5};

    rstn = 1'b0; ld = 1'b0; en = 1'b0;
    mode = '0; init = '0; lo = '0; hi = '0; step = '0;
    div = '0; per = '0;
    #12;
    chk("rst_dat", d(0), 0);
    chk("rst_stb", stb, 0);
    chk("rst_trig", trig, 1);
    chk("rst_tcnt", trig_cnt, 0);
    rstn = 1'b1;
    tick();

    // Sawtooth -1000..1000, step 1, every cycle.
    mode[0] = 2'd1; lo[0] = -14'sd1000; hi[0] = 14'sd1000; step[0] = 14'd1; init[0] = -14'sd1000;
    ld = 1'b1; tick(); ld = 1'b0; en = 1'b1;
    chk("saw_ld", d(0), -1000);
    bad = 0;
    for (int k = 1; k <= 2000; k++) begin
      tick();
      if (d(0) !== -1000 + k || stb !== 1'b1) bad++;
    end
    chk("saw_ramp", bad, 0);
    chk("saw_top", d(0), 1000);
    tick();
    chk("saw_wrap", d(0), -1000);
    chk("hold_ch2", d(2), 0);

    // Freeze mid-ramp with divider 2 and trigger period 6.
    en = 1'b0; div = 16'd2; per = 32'd6;
    ld = 1'b1; tick(); ld = 1'b0; en = 1'b1;
    tick(); tick(); tick();
    chk("frz_stb3", stb, 1);
    chk("frz_dat3", d(0), -999);
    tick(); tick(); tick(); tick();
    chk("frz_trig7", trig, 0);
    chk("frz_tcnt7", trig_cnt, 1);
    chk("frz_dat7", d(0), -998);
    en = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (d(0) !== -998 || stb !== 1'b0 || trig !== 1'b1 || trig_cnt !== 32'd1) bad++;
    end
    chk("frz_hold", bad, 0);
    en = 1'b1;
    tick();
    chk("res_stb1", stb, 0);
    tick();
    chk("res_stb2", stb, 1);
    chk("res_dat2", d(0), -997);
    bad = 0;
    for (int k = 3; k <= 6; k++) begin
      tick();
      if (trig !== 1'b1) bad++;
    end
    chk("res_trig_idle", bad, 0);
    tick();
    chk("res_trig7", trig, 0);
    chk("res_tcnt7", trig_cnt, 2);

    // Triangle -8..8 step 3 with divider 2; ch3 has lo==hi.
    en = 1'b0; per = '0; div = 16'd2;
    mode[1] = 2'd2; lo[1] = -14'sd8; hi[1] = 14'sd8; step[1] = 14'd3; init[1] = '0;
    mode[3] = 2'd2; lo[3] = 14'sd5; hi[3] = 14'sd5; step[3] = 14'd2; init[3] = 14'sd5;
    ld = 1'b1; tick(); ld = 1'b0; en = 1'b1;
    chk("tri_ld", d(1), 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); if (stb !== 1'b0) bad++;
      tick(); if (stb !== 1'b0) bad++;
      tick(); if (stb !== 1'b1) bad++;
      chk($sformatf("tri_seq%0d", i), d(1), tri_seq[i]);
    end
    chk("tri_stb_pattern", bad, 0);
    chk("tri_flat", d(3), 5);

    // LFSR with zero seed on ch2, every cycle.
    en = 1'b0; div = '0;
    mode[2] = 2'd3; init[2] = '0;
    ld = 1'b1; tick(); ld = 1'b0; en = 1'b1;
    chk("lfsr_ld", d(2), 0);
    tick(); chk("lfsr_v0", d(2), 1);
    tick(); chk("lfsr_v1", d(2), -2046);
    tick(); chk("lfsr_v2", d(2), 7169);
    tick(); chk("lfsr_v3", d(2), -2558);
    n = 3; zero = 0;
    do begin
      tick();
      n++;
      if (d(2) === 0) zero++;
    end while (d(2) !== 1 && n <= 20000);
    chk("lfsr_period", n, 16383);
    chk("lfsr_nozero", zero, 0);

    // Trigger period 250 cycles, then disabled.
    en = 1'b0; per = 32'd249;
    ld = 1'b1; tick(); ld = 1'b0; en = 1'b1;
    pulses = 0; first = 0; last = 0; bad = 0;
    for (int t = 1; t <= 1000; t++) begin
      tick();
      if (trig === 1'b0) begin
        pulses++;
        if (first == 0) first = t;
        if (last != 0 && t - last != 250) bad++;
        last = t;
      end
    end
    chk("trg_first", first, 250);
    chk("trg_pulses", pulses, 4);
    chk("trg_spacing", bad, 0);
    chk("trg_cnt4", trig_cnt, 4);
    per = '0;
    lows = 0;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (trig !== 1'b1) lows++;
    end
    chk("trg_off_lows", lows, 0);
    chk("trg_off_cnt", trig_cnt, 4);

    // ld with en=1 lands on the cycle a trigger would have fired.
    per = 32'd3;
    ld = 1'b1; tick(); ld = 1'b0;
    tick(); tick(); tick();
    init[0] = 14'sd77; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("ld_no_trig", trig, 1);
    chk("ld_dat", d(0), 77);
    chk("ld_stb", stb, 0);
    chk("ld_tcnt", trig_cnt, 0);
    tick(); tick(); tick(); tick();
    chk("ld_trig_again", trig, 0);
    chk("ld_tcnt1", trig_cnt, 1);

    // Asynchronous reset between edges.
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_dat", d(0), 0);
    chk("arst_tcnt", trig_cnt, 0);
    chk("arst_trig", trig, 1);
    #2;
    rstn = 1'b1;
    en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
